sine_address_gen: RTL and testbench

Phase-accumulator address generator that sits directly upstream of the sine/cosine lookup ROM in the sine-wave datapath. On each sample tick it issues a one-cycle ROM read enable and a table address taken from the top bits of a wrapping phase accumulator. Output frequency is set by a tuning word and sample rate by a clock divider. It also emits a valid strobe delayed to line up with the ROM's one-cycle registered read data.

---
 rtl/sine_address_gen.sv | 90 +++++++++
 tb/tb_sine_address_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sine_address_gen.sv
// Phase-accumulator address generator feeding the sine/cosine lookup ROM.
// Issues one read per sample tick and a valid strobe aligned to the ROM's registered data.
module sine_address_gen #(
  parameter int PHASE_WIDTH = 16,
  parameter int DEPTH       = 64,
  parameter int DIV_WIDTH   = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] tuning_word,
  input  logic [DIV_WIDTH-1:0]   sample_div,
  output logic                   rom_en,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  output logic                   sample_valid,
  output logic                   wrap,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] tw_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [PHASE_WIDTH:0]   phase_sum;

  // Extra bit holds the carry out of the accumulator, which drives wrap.
  assign phase_sum   = {1'b0, phase} + {1'b0, tw_q};

  assign rom_en      = (state == RUN) && (div_cnt == '0);
  assign rom_address = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      tw_q         <= '0;
      div_q        <= '0;
      div_cnt      <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= rom_en;
      wrap         <= rom_en && phase_sum[PHASE_WIDTH];
      case (state)
        IDLE: begin
          if (start && !stop) begin
            tw_q    <= tuning_word;
            div_q   <= sample_div;
            phase   <= '0;
            div_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Stop beats start; a read issued in the stop cycle is still reported next cycle.
          if (stop) begin
            state <= DRAIN;
          end else if (start) begin
            tw_q    <= tuning_word;
            div_q   <= sample_div;
            phase   <= '0;
            div_cnt <= '0;
          end else if (rom_en) begin
            phase   <= phase_sum[PHASE_WIDTH-1:0];
            div_cnt <= div_q;
          end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_address_gen.sv
// Directed bench for sine_address_gen: a vector table plus hand-written sequences
// for the full address sweep, resync, stop draining and mid-run reset.
module tb_sine_address_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] tuning_word;
  logic [15:0] sample_div;
  logic        rom_en;
  logic [5:0]  rom_address;
  logic        sample_valid;
  logic        wrap;
  logic        busy;

  int checks;
  int passed;

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] tw;
    logic [15:0] div;
    logic        en;
    logic [5:0]  addr;
    logic        chk_addr;
    logic        sv;
    logic        wrap;
    logic        busy;
  } vec_t;

  vec_t vecs[20];

  sine_address_gen #(
    .PHASE_WIDTH(16),
    .DEPTH(64),
    .DIV_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .tuning_word(tuning_word),
    .sample_div(sample_div),
    .rom_en(rom_en),
    .rom_address(rom_address),
    .sample_valid(sample_valid),
    .wrap(wrap),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic s, input logic p, input logic [15:0] tw,
                               input logic [15:0] dv);
    @(negedge clk);
    start       = s;
    stop        = p;
    tuning_word = tw;
    sample_div  = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_en, input logic [5:0] e_addr,
                             input logic chk_addr, input logic e_sv, input logic e_wrap,
                             input logic e_busy);
    logic ok;
    ok = (rom_en === e_en) && (sample_valid === e_sv) && (wrap === e_wrap) &&
         (busy === e_busy) && (!chk_addr || (rom_address === e_addr));
    checks++;
    if (ok) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got en=%b addr=%0d sv=%b wrap=%b busy=%b, want en=%b addr=%0d%s sv=%b wrap=%b busy=%b",
               name, rom_en, rom_address, sample_valid, wrap, busy,
               e_en, e_addr, chk_addr ? "" : "(any)", e_sv, e_wrap, e_busy);
    end
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    tuning_word = '0;
    sample_div  = '0;

    //           start stop tw       div    en   addr  chk  sv   wrap busy
    vecs[0]  = '{1'b1, 1'b0, 16'h8000, 16'd0, 1'b1, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'd0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0400, 16'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0400, 16'd3, 1'b1, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd1,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd2,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'h0800, 16'd0, 1'b1, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd2,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd4,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b1, 6'd6,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 16'h0000, 16'd0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};

    // Power-on reset held three cycles, then idle with no start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset_hold%0d", i), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h1234, 16'd0);
      checkOutput($sformatf("post_reset%0d", i), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].tw, vecs[i].div);
      checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].chk_addr,
                  vecs[i].sv, vecs[i].wrap, vecs[i].busy);
    end

    // Full sweep with tw=0x0400, div=0: addresses 0..63 then 0,1,..,20; wrap follows address 63.
    for (int j = 0; j <= 84; j++) begin
      applyStimulus(j == 0, 1'b0, 16'h0400, 16'd0);
      checkOutput($sformatf("sweep%0d", j), 1'b1, 6'(j % 64), 1'b1, j > 0,
                  (j > 0) && (((j - 1) % 64) == 63), 1'b1);
    end

    // Resync at address 20 with tw=0x0800: the address-20 read still reports valid.
    applyStimulus(1'b1, 1'b0, 16'h0800, 16'd0);
    checkOutput("resync0", 1'b1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
      checkOutput($sformatf("resync%0d", k), 1'b1, 6'(2 * k), 1'b1, 1'b1, 1'b0, 1'b1);
    end

    // Back to tw=0x0400, stop while address 5 is being read.
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'd0);
    checkOutput("restart0", 1'b1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
      checkOutput($sformatf("restart%0d", k), 1'b1, 6'(k), 1'b1, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'd0);
    checkOutput("stop_drain", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'd0);
    checkOutput("stop_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
    checkOutput("stop_quiet", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted between clock edges mid-run must clear outputs immediately.
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'd0);
    checkOutput("mid_run0", 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
    checkOutput("mid_run1", 1'b1, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("mid_reset_hold%0d", i), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
      checkOutput($sformatf("mid_reset_after%0d", i), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
